dmem_arbiter: RTL and testbench

- Sequences all accesses to the single-port data memory (dataMem: clk, Add, wEn, M_valA, rEn, m_valM, dmem_err).
- Arbitrates between two requesters: the pipeline memory stage (port m) and the debug/program loader (port d).
- Guarantees wEn and rEn are never asserted together.
- Checks addresses before issue and returns read data plus error status through a req/ack handshake.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arb_sel.sv | 50 +++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    // Access sequencer states: IDLE picks a winner, ACCESS drives the memory
    // for exactly one cycle, RESP returns the result with a one-cycle ack.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester ids as stored in the winner register.
    localparam logic REQ_M = 1'b0;  // pipeline memory stage
    localparam logic REQ_D = 1'b1;  // debug / program loader

    // Default number of 64-bit words in the data memory.
    localparam int DMEM_DEPTH = 1024;

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner select between the pipeline (m) and debug (d) requesters.
// Latency: combinational select; the round-robin pointer updates on the grant edge.
// Backpressure: none; the loser simply keeps its request high and is re-evaluated.
//
// Ports: clk, rst_n (async active-low), m_req, d_req (raw requests),
//        grant_en (a grant is taken this cycle), winner (REQ_M / REQ_D).
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise m has fixed priority.
module dmem_arb_sel
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic m_req,
    input  logic d_req,
    input  logic grant_en,
    output logic winner
);

`ifdef DMEM_ARB_RR_EN
    // Id of the requester granted most recently. Resets to d so that the
    // first contended grant after reset goes to m.
    logic last_grant;

    always_comb begin
        winner = REQ_M;
        if (m_req && d_req) begin
            // Under contention the requester not served last time wins.
            winner = ~last_grant;
        end else if (d_req) begin
            winner = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_D;
        end else if (grant_en) begin
            last_grant <= winner;
        end
    end
`else
    // Fixed priority: d only wins when m is not asking.
    assign winner = (d_req && !m_req) ? REQ_D : REQ_M;

    // The pointer does not exist in this build; these inputs are intentionally idle.
    logic unused_sel;
    assign unused_sel = &{1'b0, clk, rst_n, grant_en};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences pipeline (m) and debug (d) accesses onto the single-port data memory.
// Latency: 3 cycles per in-range access (IDLE, ACCESS, RESP), 2 for an out-of-range address.
// Backpressure: req/ack handshake; a losing requester holds req until its own ack.
//
// Ports: clk, rst_n (async active-low);
//        m_req/m_we/m_addr/m_wdata -> m_ack   pipeline port
//        d_req/d_we/d_addr/d_wdata -> d_ack   debug port
//        rsp_rdata/rsp_err                    response, valid only while an ack is high
//        mem_addr/mem_wen/mem_ren/mem_wdata   to the memory (Add, wEn, rEn, M_valA)
//        mem_rdata/mem_err                    from the memory (m_valM, dmem_err)
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration in dmem_arb_sel.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m_req,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    output logic          m_ack,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,

    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,

    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_err
);

    // Full-width limit so high address bits are never silently dropped.
    localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

    state_t        state;
    logic          cmd_we;     // latched access type of the current command
    logic          cmd_id;     // latched winner id of the current command

    logic          winner;
    logic          grant_en;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_in_range;

    // A grant is only taken from IDLE; requests seen in ACCESS/RESP wait.
    assign grant_en = (state == IDLE) && (m_req || d_req);

    dmem_arb_sel u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .winner   (winner)
    );

    assign sel_we       = (winner == REQ_D) ? d_we    : m_we;
    assign sel_addr     = (winner == REQ_D) ? d_addr  : m_addr;
    assign sel_wdata    = (winner == REQ_D) ? d_wdata : m_wdata;
    assign sel_in_range = (sel_addr < DEPTH_AW);

    // mem_addr/mem_wdata double as the latched address/data of the command;
    // the enables are only ever set in the IDLE->ACCESS transition and set
    // to complementary values, so wEn and rEn can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            cmd_id    <= REQ_M;
            m_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        cmd_id <= winner;
                        cmd_we <= sel_we;
                        if (sel_in_range) begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_wen   <= sel_we;
                            mem_ren   <= !sel_we;
                            state     <= ACCESS;
                        end else begin
                            // Out of range: never touch the memory, answer
                            // directly with an error in the next cycle.
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            m_ack     <= (winner == REQ_M);
                            d_ack     <= (winner == REQ_D);
                            state     <= RESP;
                        end
                    end
                end

                ACCESS: begin
                    rsp_rdata <= cmd_we ? '0 : mem_rdata;
                    rsp_err   <= mem_err;
                    mem_wen   <= 1'b0;
                    mem_ren   <= 1'b0;
                    m_ack     <= (cmd_id == REQ_M);
                    d_ack     <= (cmd_id == REQ_D);
                    state     <= RESP;
                end

                RESP: begin
                    m_ack     <= 1'b0;
                    d_ack     <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a behavioural memory.
// Latency: expects ack in cycle 3 (in range) or cycle 2 (out of range) after req.
// Backpressure: drives req/ack handshakes on both ports, dropping req on ack.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req, m_we, m_ack;
    logic [63:0] m_addr, m_wdata;
    logic        d_req, d_we, d_ack;
    logic [63:0] d_addr, d_wdata;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen, mem_ren, mem_err;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    // Behavioural single-port memory: combinational read, write on the edge.
    logic [63:0] bmem   [0:DEPTH-1];
    logic [63:0] shadow [0:DEPTH-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) bmem[i] = 64'h0;
        bmem[3] = 64'h0000_0000_0000_A5A5;
        bmem[5] = 64'h0000_0000_DEAD_BEEF;
    end

    assign mem_rdata = mem_ren ? bmem[mem_addr[9:0]] : 64'h0;

    always @(posedge clk) begin
        if (mem_wen) bmem[mem_addr[9:0]] <= mem_wdata;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle-by-cycle invariants while out of reset.
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("wen_ren_excl", {63'b0, mem_wen & mem_ren}, 64'd0);
            check("one_ack", {63'b0, m_ack & d_ack}, 64'd0);
            if (mem_wen || mem_ren)
                check("mem_addr_rng", {63'b0, (mem_addr < 64'd1024)}, 64'd1);
        end
    end

    task automatic drive(input bit is_d, input bit req, input bit we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (is_d) begin
            d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            m_req = req; m_we = we; m_addr = addr; m_wdata = wdata;
        end
    endtask

    // One directed access; lat counts the request cycle as cycle 1.
    task automatic access(input bit is_d, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rd,
                          output logic er, output int lat, output int wc, output int rc);
        rd = 64'h0; er = 1'b0; lat = 0; wc = 0; rc = 0;
        @(negedge clk);
        drive(is_d, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_wen) wc++;
            if (mem_ren) rc++;
            if (is_d ? d_ack : m_ack) begin
                lat = i + 1;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
        end
        drive(is_d, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    // Random requester with a shadow-memory scoreboard.
    task automatic rand_port(input bit is_d, input int n);
        logic [63:0] addr, wdata, exp_rd;
        logic        we, exp_err, acked;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? 64'd1024 + 64'($urandom_range(0, 5000))
                                                : 64'd16 + 64'($urandom_range(0, 15));
            wdata = {$urandom, $urandom};
            drive(is_d, 1'b1, we, addr, wdata);
            acked = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (is_d ? d_ack : m_ack) begin
                    acked = 1'b1;
                    if (addr >= 64'd1024) begin
                        exp_rd = 64'h0; exp_err = 1'b1;
                    end else if (we) begin
                        exp_rd = 64'h0; exp_err = 1'b0;
                        shadow[addr[9:0]] = wdata;
                    end else begin
                        exp_rd = shadow[addr[9:0]]; exp_err = 1'b0;
                    end
                    check("rand_rdata", rsp_rdata, exp_rd);
                    check("rand_err", {63'b0, rsp_err}, {63'b0, exp_err});
                    break;
                end
            end
            check("rand_ack", {63'b0, acked}, 64'd1);
            drive(is_d, 1'b0, 1'b0, 64'h0, 64'h0);
        end
    endtask

    logic [63:0] rd, m_rd, d_rd;
    logic        er;
    int          lat, wc, rc, m_lat, d_lat, n_ack, acks;
    int          order [4];
    int          when  [4];
    int          exp_order [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = 64'h0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        mem_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_ack", {63'b0, m_ack}, 64'd0);
        check("rst_d_ack", {63'b0, d_ack}, 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_err", {63'b0, rsp_err}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_wen", {63'b0, mem_wen}, 64'd0);
        check("rst_ren", {63'b0, mem_ren}, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // m read of word 5
        access(1'b0, 1'b0, 64'd5, 64'h0, rd, er, lat, wc, rc);
        check("rd5_lat", 64'(lat), 64'd3);
        check("rd5_data", rd, 64'hDEAD_BEEF);
        check("rd5_err", {63'b0, er}, 64'd0);
        check("rd5_ren_cyc", 64'(rc), 64'd1);
        check("rd5_wen_cyc", 64'(wc), 64'd0);

        // d write of word 10, then m reads it back
        access(1'b1, 1'b1, 64'd10, 64'h1234, rd, er, lat, wc, rc);
        check("wr10_lat", 64'(lat), 64'd3);
        check("wr10_wen_cyc", 64'(wc), 64'd1);
        check("wr10_ren_cyc", 64'(rc), 64'd0);
        check("wr10_rdata", rd, 64'd0);
        access(1'b0, 1'b0, 64'd10, 64'h0, rd, er, lat, wc, rc);
        check("rd10_data", rd, 64'h1234);
        check("rd10_err", {63'b0, er}, 64'd0);

        // Out-of-range addresses: just past the end, and a high-bit alias of 3
        access(1'b0, 1'b0, 64'd1024, 64'h0, rd, er, lat, wc, rc);
        check("oor_lat", 64'(lat), 64'd2);
        check("oor_err", {63'b0, er}, 64'd1);
        check("oor_rdata", rd, 64'd0);
        check("oor_en_cyc", 64'(wc + rc), 64'd0);
        access(1'b1, 1'b1, 64'h1_0000_0003, 64'hFFFF, rd, er, lat, wc, rc);
        check("hi_lat", 64'(lat), 64'd2);
        check("hi_err", {63'b0, er}, 64'd1);
        check("hi_wen_cyc", 64'(wc), 64'd0);
        check("hi_no_write", bmem[3], 64'hA5A5);

        // Memory-reported error passes through with the read data
        mem_err = 1'b1;
        access(1'b0, 1'b0, 64'd3, 64'h0, rd, er, lat, wc, rc);
        mem_err = 1'b0;
        check("merr_err", {63'b0, er}, 64'd1);
        check("merr_rdata", rd, 64'hA5A5);

        // Fresh reset so both arbitration builds start pointing at m
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Simultaneous requests, each dropped on its own ack
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'd5, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 64'd10, 64'h0);
        m_lat = 0; d_lat = 0; m_rd = 64'h0; d_rd = 64'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (m_ack) begin m_lat = i + 1; m_rd = rsp_rdata; m_req = 1'b0; end
            if (d_ack) begin d_lat = i + 1; d_rd = rsp_rdata; d_req = 1'b0; end
            if (m_lat != 0 && d_lat != 0) break;
        end
        m_req = 1'b0; d_req = 1'b0;
        check("sim_m_lat", 64'(m_lat), 64'd3);
        check("sim_d_lat", 64'(d_lat), 64'd6);
        check("sim_m_data", m_rd, 64'hDEAD_BEEF);
        check("sim_d_data", d_rd, 64'h1234);

        // Both held continuously for four acks
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin order[k] = -1; when[k] = 0; end
        n_ack = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'd5, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 64'd10, 64'h0);
        for (int i = 1; i <= 40 && n_ack < 4; i++) begin
            @(negedge clk);
            if (m_ack) begin order[n_ack] = 0; when[n_ack] = i; n_ack++; end
            else if (d_ack) begin order[n_ack] = 1; when[n_ack] = i; n_ack++; end
        end
        m_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++)
            check($sformatf("held_order%0d", k), 64'(order[k]), 64'(exp_order[k]));
        for (int k = 1; k < 4; k++)
            check($sformatf("held_gap%0d", k), 64'(when[k] - when[k-1]), 64'd3);

        // Reset asserted while a read is in ACCESS
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'd5, 64'h0);
        @(negedge clk);
        check("acc_ren_before_rst", {63'b0, mem_ren}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("acc_rst_ren", {63'b0, mem_ren}, 64'd0);
        check("acc_rst_wen", {63'b0, mem_wen}, 64'd0);
        check("acc_rst_ack", {62'b0, m_ack, d_ack}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0; rd = 64'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_ack) acks += 100;
            if (m_ack) begin acks++; rd = rsp_rdata; m_req = 1'b0; end
        end
        check("acc_rst_acks", 64'(acks), 64'd1);
        check("acc_rst_data", rd, 64'hDEAD_BEEF);

        // Random traffic on both ports
        fork
            rand_port(1'b0, 1000);
            rand_port(1'b1, 1000);
        join

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
